serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 84 ++++++++
 tb/tb_serial_adder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - multi-cycle adder/subtractor, DIGIT bits per clock, LSD first
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C,
  input  logic             Sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cy,
  output logic             Ov
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] a_d;
  logic [DIGIT-1:0] b_d;
  logic [DIGIT-1:0] sum_d;
  logic             c_out;

  assign a_d = a_q[cnt*DIGIT +: DIGIT];
  assign b_d = b_q[cnt*DIGIT +: DIGIT];
  assign {c_out, sum_d} = {1'b0, a_d} + {1'b0, b_d} + {{DIGIT{1'b0}}, carry};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      S     <= '0;
      Cy    <= 1'b0;
      Ov    <= 1'b0;
      carry <= 1'b0;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Subtraction is A + ~B + ~C, so invert B and the borrow-in up front
            a_q   <= A;
            b_q   <= Sub ? ~B : B;
            carry <= Sub ? ~C : C;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          S[cnt*DIGIT +: DIGIT] <= sum_d;
          carry <= c_out;
          if (cnt == LAST) begin
            Cy    <= c_out;
            Ov    <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[DIGIT-1] != a_q[WIDTH-1]);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder, DIGIT=1 and DIGIT=4 instances
module tb_serial_adder;

  typedef struct packed {
    logic [7:0] s;
    logic       cy;
    logic       ov;
  } res_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start [2];
  logic [7:0] a     [2];
  logic [7:0] b     [2];
  logic       c     [2];
  logic       sub   [2];
  logic       busy  [2];
  logic       done  [2];
  logic [7:0] s     [2];
  logic       cy    [2];
  logic       ov    [2];

  int   rem      [2];
  logic exp_done [2];
  res_t q0[$];
  res_t q1[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic chk_en = 1'b0;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start[0]), .A(a[0]), .B(b[0]), .C(c[0]), .Sub(sub[0]),
    .busy(busy[0]), .done(done[0]), .S(s[0]), .Cy(cy[0]), .Ov(ov[0])
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .start(start[1]), .A(a[1]), .B(b[1]), .C(c[1]), .Sub(sub[1]),
    .busy(busy[1]), .done(done[1]), .S(s[1]), .Cy(cy[1]), .Ov(ov[1])
  );

  initial forever #5 clk = ~clk;

  // Reference: plain integer arithmetic, signed overflow from the true signed result
  function automatic res_t model(input logic [7:0] av, input logic [7:0] bv,
                                 input logic cv, input logic subv);
    res_t r;
    int ua, ub, uc, sa, sb, us, ss;
    ua = av;
    ub = bv;
    uc = cv;
    sa = $signed(av);
    sb = $signed(bv);
    if (!subv) begin
      us   = ua + ub + uc;
      ss   = sa + sb + uc;
      r.cy = (us > 255);
    end else begin
      us   = ua - ub - uc;
      ss   = sa - sb - uc;
      r.cy = (us >= 0);
    end
    r.s  = us[7:0];
    r.ov = (ss > 127) || (ss < -128);
    return r;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[dut%0d] t=%0t: got %0h, expected %0h", name, idx, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      exp_done[i] = 1'b0;
      if (rst) begin
        rem[i] = 0;
        if (i == 0) q0.delete(); else q1.delete();
      end else if (rem[i] > 0) begin
        rem[i]--;
        if (rem[i] == 0) exp_done[i] = 1'b1;
      end else if (start[i]) begin
        rem[i] = (i == 0) ? 8 : 2;
        if (i == 0) q0.push_back(model(a[i], b[i], c[i], sub[i]));
        else        q1.push_back(model(a[i], b[i], c[i], sub[i]));
      end
    end
    #1;
  endtask

  task automatic scramble(input int i);
    a[i]   = 8'($urandom);
    b[i]   = 8'($urandom);
    c[i]   = 1'($urandom);
    sub[i] = 1'($urandom);
  endtask

  task automatic op(input int i, input logic [7:0] av, input logic [7:0] bv,
                    input logic cv, input logic subv);
    a[i]     = av;
    b[i]     = bv;
    c[i]     = cv;
    sub[i]   = subv;
    start[i] = 1'b1;
    tick();
    start[i] = 1'b0;
    scramble(i);
    while (rem[i] > 0) tick();
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        res_t r;
        chk("busy", i, 32'(busy[i]), 32'(rem[i] > 0));
        chk("done", i, 32'(done[i]), 32'(exp_done[i]));
        if (done[i] || exp_done[i]) begin
          if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
            n_cmp++;
            n_err++;
            $display("FAIL result_queue[dut%0d] t=%0t: got done with no pending operation", i, $time);
          end else begin
            if (i == 0) r = q0.pop_front(); else r = q1.pop_front();
            chk("S",  i, 32'(s[i]),  32'(r.s));
            chk("Cy", i, 32'(cy[i]), 32'(r.cy));
            chk("Ov", i, 32'(ov[i]), 32'(r.ov));
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; a[i] = '0; b[i] = '0; c[i] = 1'b0; sub[i] = 1'b0;
      rem[i] = 0; exp_done[i] = 1'b0;
    end
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", i, 32'(busy[i]), 32'd0);
      chk("rst_done", i, 32'(done[i]), 32'd0);
      chk("rst_S",    i, 32'(s[i]),    32'd0);
      chk("rst_Cy",   i, 32'(cy[i]),   32'd0);
      chk("rst_Ov",   i, 32'(ov[i]),   32'd0);
    end
    chk_en = 1'b1;

    op(0, 8'hFF, 8'h01, 1'b0, 1'b0);
    op(0, 8'h7F, 8'h01, 1'b0, 1'b0);
    op(0, 8'h80, 8'h01, 1'b0, 1'b1);
    op(0, 8'h05, 8'h07, 1'b0, 1'b1);
    op(0, 8'h05, 8'h07, 1'b1, 1'b1);
    op(0, 8'h80, 8'h80, 1'b0, 1'b1);
    op(1, 8'h3C, 8'h4B, 1'b1, 1'b0);
    op(1, 8'h00, 8'h00, 1'b1, 1'b1);
    tick();

    for (int k = 0; k < 40; k++) begin
      op(0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      op(1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) tick();
    end

    // start held high: only operands present while idle may be taken
    start[0] = 1'b1;
    start[1] = 1'b1;
    for (int k = 0; k < 60; k++) begin
      scramble(0);
      scramble(1);
      tick();
    end
    start[0] = 1'b0;
    start[1] = 1'b0;
    while (rem[0] > 0 || rem[1] > 0) tick();
    tick();

    a[0] = 8'hA5; b[0] = 8'h3C; c[0] = 1'b1; sub[0] = 1'b0; start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_S",  0, 32'(s[0]),  32'd0);
    chk("abort_Cy", 0, 32'(cy[0]), 32'd0);
    chk("abort_Ov", 0, 32'(ov[0]), 32'd0);
    repeat (10) tick();
    op(0, 8'hC8, 8'h64, 1'b0, 1'b1);
    op(0, 8'h12, 8'h34, 1'b1, 1'b0);
    tick();
    tick();

    chk("pending_q0", 0, 32'(q0.size()), 32'd0);
    chk("pending_q1", 1, 32'(q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
